// File: rtl/hex_conv_arbiter.sv
// hex_conv_arbiter: two requesters share one iterative binary-to-BCD/octal
// converter. A round-robin grant picks the operand. Double-dabble then runs
// one bit per clock, and the result is held under a valid/ready handshake.
module hex_conv_arbiter #(
    parameter int W      = 16,
    parameter int DIGITS = 5,
    localparam int OCT_W = 3 * ((W + 2) / 3)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [W-1:0]          req_hex0,
    input  logic [W-1:0]          req_hex1,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [W-1:0]          rsp_bin,
    output logic [OCT_W-1:0]      rsp_oct,
    output logic [4*DIGITS-1:0]   rsp_bcd,
    output logic                  busy
);

    localparam int CNT_W = $clog2(W + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;          // requester favoured on a tie
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_acc_q, bcd_acc_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [W-1:0]       rsp_bin_q, rsp_bin_d;
    logic [OCT_W-1:0]   rsp_oct_q, rsp_oct_d;
    logic [BCD_W-1:0]   rsp_bcd_q, rsp_bcd_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_next;
    logic               grant_valid;
    logic               grant_id;
    logic [W-1:0]       grant_hex;

    // Add-3 correction: any digit of 5 or more would overflow after doubling.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign bcd_adj[gi*4 +: 4] = (bcd_acc_q[gi*4 +: 4] >= 4'd5)
                                      ? bcd_acc_q[gi*4 +: 4] + 4'd3
                                      : bcd_acc_q[gi*4 +: 4];
        end
    endgenerate

    // Corrected digits shift left; the operand MSB enters BCD bit 0.
    assign bcd_next = (bcd_adj << 1) | {{(BCD_W-1){1'b0}}, shift_q[W-1]};

    // Arbitration, handshakes and the conversion sequence.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        bcd_acc_d   = bcd_acc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_bin_d   = rsp_bin_q;
        rsp_oct_d   = rsp_oct_q;
        rsp_bcd_d   = rsp_bcd_q;
        req_ready   = 2'b00;
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        grant_hex   = req_hex0;

        case (state_q)
            S_IDLE: begin
                grant_valid = |req_valid;
                // The pointer only matters on a tie; a lone requester always wins.
                grant_id    = (req_valid == 2'b11) ? ptr_q : req_valid[1];
                grant_hex   = grant_id ? req_hex1 : req_hex0;
                if (grant_valid) begin
                    req_ready = grant_id ? 2'b10 : 2'b01;
                    shift_d   = grant_hex;
                    rsp_bin_d = grant_hex;
                    rsp_oct_d = OCT_W'(grant_hex);
                    rsp_id_d  = grant_id;
                    bcd_acc_d = '0;
                    cnt_d     = '0;
                    ptr_d     = ~grant_id;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_acc_d = bcd_next;
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(W - 1)) begin
                    rsp_bcd_d   = bcd_next;
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset also drops any in-flight result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            bcd_acc_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_bin_q   <= '0;
            rsp_oct_q   <= '0;
            rsp_bcd_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            bcd_acc_q   <= bcd_acc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_bin_q   <= rsp_bin_d;
            rsp_oct_q   <= rsp_oct_d;
            rsp_bcd_q   <= rsp_bcd_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_bin   = rsp_bin_q;
    assign rsp_oct   = rsp_oct_q;
    assign rsp_bcd   = rsp_bcd_q;
    assign busy      = (state_q != S_IDLE);

endmodule
